// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared types and elaboration helpers for the barrel shifter
package shifter_pkg;

   typedef enum logic {
      SHIFT_LEFT  = 1'b0,
      SHIFT_RIGHT = 1'b1
   } shift_dir_t;

   function automatic bit is_pow2(input int unsigned v);
      return (v >= 2) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// rtl/barrel_shift_stage.sv - one registered stage: conditional shift by 2^K plus sideband pass-through
module barrel_shift_stage
   import shifter_pkg::*;
#(
   parameter int N  = 8,
   parameter int SW = 3,
   parameter int K  = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          vld_i,
   input  logic [N-1:0]  data_i,
   input  logic [SW-1:0] shamt_i,
   input  shift_dir_t    dir_i,
   input  logic          arith_i,
   input  logic          sign_i,
   output logic          vld_o,
   output logic [N-1:0]  data_o,
   output logic [SW-1:0] shamt_o,
   output shift_dir_t    dir_o,
   output logic          arith_o,
   output logic          sign_o
);

   localparam int S = 1 << K;

   logic          vld_q,   vld_d;
   logic [N-1:0]  data_q,  data_d;
   logic [SW-1:0] shamt_q, shamt_d;
   shift_dir_t    dir_q,   dir_d;
   logic          arith_q, arith_d;
   logic          sign_q,  sign_d;
   logic [N-1:0]  shifted;

   // Fill comes from the sign captured at stage 0, never from the partially shifted data.
   always_comb begin
      shifted = data_i;
      if (shamt_i[K]) begin
         if (dir_i == SHIFT_LEFT) begin
            shifted = {data_i[N-1-S:0], {S{1'b0}}};
         end else begin
            shifted = {{S{arith_i & sign_i}}, data_i[N-1:S]};
         end
      end
   end

   // Bubbles clear valid but leave data and sideband untouched.
   always_comb begin
      vld_d   = vld_i;
      data_d  = data_q;
      shamt_d = shamt_q;
      dir_d   = dir_q;
      arith_d = arith_q;
      sign_d  = sign_q;
      if (vld_i) begin
         data_d  = shifted;
         shamt_d = shamt_i;
         dir_d   = dir_i;
         arith_d = arith_i;
         sign_d  = sign_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q   <= 1'b0;
         data_q  <= '0;
         shamt_q <= '0;
         dir_q   <= SHIFT_LEFT;
         arith_q <= 1'b0;
         sign_q  <= 1'b0;
      end else begin
         vld_q   <= vld_d;
         data_q  <= data_d;
         shamt_q <= shamt_d;
         dir_q   <= dir_d;
         arith_q <= arith_d;
         sign_q  <= sign_d;
      end
   end

   assign vld_o   = vld_q;
   assign data_o  = data_q;
   assign shamt_o = shamt_q;
   assign dir_o   = dir_q;
   assign arith_o = arith_q;
   assign sign_o  = sign_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - log2(N)-stage pipelined barrel shifter, one shamt bit per stage
module pipelined_barrel_shifter
   import shifter_pkg::*;
#(
   parameter  int N  = 8,
   localparam int SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          up_vld,
   input  logic [N-1:0]  up_data,
   input  logic [SW-1:0] up_shamt,
   input  logic          up_dir,
   input  logic          up_arith,
   output logic          down_vld,
   output logic [N-1:0]  down_data
);

   if (!is_pow2(N)) begin : g_bad_width
      $error("pipelined_barrel_shifter: N must be a power of two >= 2");
   end

   logic          c_vld   [0:SW];
   logic [N-1:0]  c_data  [0:SW];
   logic [SW-1:0] c_shamt [0:SW];
   shift_dir_t    c_dir   [0:SW];
   logic          c_arith [0:SW];
   logic          c_sign  [0:SW];

   assign c_vld[0]   = up_vld;
   assign c_data[0]  = up_data;
   assign c_shamt[0] = up_shamt;
   assign c_dir[0]   = shift_dir_t'(up_dir);
   assign c_arith[0] = up_arith;
   assign c_sign[0]  = up_data[N-1];

   for (genvar k = 0; k < SW; k++) begin : g_stage
      barrel_shift_stage #(
         .N  (N),
         .SW (SW),
         .K  (k)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .vld_i   (c_vld[k]),
         .data_i  (c_data[k]),
         .shamt_i (c_shamt[k]),
         .dir_i   (c_dir[k]),
         .arith_i (c_arith[k]),
         .sign_i  (c_sign[k]),
         .vld_o   (c_vld[k+1]),
         .data_o  (c_data[k+1]),
         .shamt_o (c_shamt[k+1]),
         .dir_o   (c_dir[k+1]),
         .arith_o (c_arith[k+1]),
         .sign_o  (c_sign[k+1])
      );
   end

   assign down_vld  = c_vld[SW];
   assign down_data = c_data[SW];

   // The last stage's sideband has no consumer.
   logic unused_tail;
   assign unused_tail = ^{c_shamt[SW], c_dir[SW], c_arith[SW], c_sign[SW]};

endmodule
